// File: rtl/usb_fifo_pkg.sv
// usb_fifo_pkg: shared FSM state type and last-beat tkeep helper for the FIFO packetizer
package usb_fifo_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  localparam int MAX_BYTES = 64;
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned rem);
    return (rem == 0) ? '1 : (MAX_BYTES'(1) << rem) - MAX_BYTES'(1);
  endfunction
endpackage

// File: rtl/axis_skid_buf2.sv
// axis_skid_buf2: two-entry buffer holding captured FIFO words until the stream accepts them
module axis_skid_buf2 #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2];
  logic wp, rp, do_push, do_pop;
  assign do_pop = pop && occ != 2'd0;
  assign do_push = push && (occ != 2'd2 || do_pop);
  assign head = mem[rp];
  // ring of two entries; a push into a full buffer without a pop is dropped
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      occ <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (clear) begin
      wp <= 1'b0;
      rp <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (do_push) mem[wp] <= din;
      wp <= do_push ? !wp : wp;
      rp <= do_pop ? !rp : rp;
      occ <= occ + 2'(do_push) - 2'(do_pop);
    end
endmodule

// File: rtl/fifo_axis_packetizer.sv
// fifo_axis_packetizer: pops a byte-length packet from the read side of a FIFO and streams it as AXI4-Stream beats
module fifo_axis_packetizer
  import usb_fifo_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [DSIZE-1:0]   fifo_read_data,
  input  logic               fifo_empty,
  output logic               fifo_read_enable,
  input  logic               cmd_valid,
  input  logic [LEN_W-1:0]   cmd_len,
  output logic               cmd_ready,
  output logic [DSIZE-1:0]   m_axis_tdata,
  output logic [DSIZE/8-1:0] m_axis_tkeep,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               busy,
  output logic               done
);
  localparam int BYTES = DSIZE / 8;
  localparam int REM_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int W = DSIZE + BYTES + 1;
  state_t state;
  logic [LEN_W-1:0] rd_left, cmd_words;
  logic [REM_W-1:0] rem, cmd_rem;
  logic [BYTES-1:0] infl_keep, rd_keep;
  logic [1:0] occ;
  logic [2:0] credit;
  logic [W-1:0] head;
  logic inflight, infl_last, rd_last, pop;
  assign cmd_rem = REM_W'(cmd_len % LEN_W'(BYTES));
  assign cmd_words = cmd_len / LEN_W'(BYTES) + LEN_W'(cmd_rem != '0);
  assign pop = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = occ != 2'd0;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = head;
  assign credit = 3'(occ) + 3'(inflight) - 3'(pop);
  assign fifo_read_enable = state == STREAM && !clear && !fifo_empty && rd_left != '0 && credit < 3'd2;
  assign rd_last = rd_left == LEN_W'(1);
  assign rd_keep = rd_last ? BYTES'(keep_mask(32'(rem))) : '1;
  axis_skid_buf2 #(.W(W)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .push (inflight),
    .din  ({fifo_read_data, infl_keep, infl_last}),
    .pop  (pop),
    .occ  (occ),
    .head (head)
  );
  // packet FSM, read-issue tracking and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      rd_left <= '0;
      rem <= '0;
      inflight <= 1'b0;
      infl_keep <= '0;
      infl_last <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      rd_left <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_read_enable;
      infl_keep <= rd_keep;
      infl_last <= rd_last;
      rd_left <= fifo_read_enable ? rd_left - LEN_W'(1) : rd_left;
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy <= 1'b1;
            state <= (cmd_len == '0) ? DONE : STREAM;
            done <= cmd_len == '0;
            rd_left <= cmd_words;
            rem <= cmd_rem;
          end
        end
        STREAM: begin
          state <= (pop && m_axis_tlast) ? DONE : STREAM;
          done <= pop && m_axis_tlast;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fifo_axis_packetizer.sv
// tb_fifo_axis_packetizer: directed packets against a queue-based FIFO and beat model
module tb_fifo_axis_packetizer;
  logic clk = 1'b0, rst = 1'b0, clear = 1'b0, fifo_empty = 1'b1, cmd_valid = 1'b0, m_axis_tready = 1'b1;
  logic [31:0] fifo_read_data = '0;
  logic [15:0] cmd_len = '0;
  logic fifo_read_enable, cmd_ready, m_axis_tlast, m_axis_tvalid, busy, done;
  logic [31:0] m_axis_tdata;
  logic [3:0] m_axis_tkeep;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
  beat_t exp_q[$];
  logic [31:0] fifo_q[$];
  int errors = 0, checks = 0, cyc = 0, outst = 0;
  int nbeats = 0, npops = 0, first_cyc = 0, last_cyc = 0, acc_cyc = 0, gap = 0;
  logic [3:0] last_keep = '0;
  logic done_seen = 1'b0, done_next = 1'b0, rd_s = 1'b0;

  fifo_axis_packetizer #(.DSIZE(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .fifo_read_data(fifo_read_data), .fifo_empty(fifo_empty), .fifo_read_enable(fifo_read_enable),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // one clock: compare outputs against the model at negedge, then serve the FIFO just after posedge
  task automatic step();
    @(negedge clk);
    chk("done", 64'(done), 64'(done_next));
    if (done) done_seen = 1'b1;
    done_next = 1'b0;
    if (fifo_read_enable) chk("read_while_empty", 64'(fifo_empty), 64'(0));
    chk("in_flight_le_2", 64'(outst <= 2), 64'(1));
    if (m_axis_tvalid) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        chk("beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'(exp_q[0]));
        if (m_axis_tready && !clear) begin
          if (nbeats == 0) first_cyc = cyc;
          last_cyc = cyc;
          last_keep = m_axis_tkeep;
          nbeats++;
          done_next = exp_q[0].l;
          void'(exp_q.pop_front());
        end
      end
    end else if (busy && nbeats > 0) gap++;
    if (cmd_valid && cmd_ready && !clear) begin
      acc_cyc = cyc;
      done_next = cmd_len == 16'd0;
    end
    rd_s = fifo_read_enable;
    outst += int'(rd_s) - int'(m_axis_tvalid && m_axis_tready);
    if (clear) begin
      done_next = 1'b0;
      outst = 0;
      exp_q.delete();
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rd_s) begin
      fifo_read_data = fifo_q.pop_front();
      npops++;
    end
    fifo_empty = fifo_q.size() == 0;
  endtask

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
    fifo_empty = fifo_q.size() == 0;
  endtask

  task automatic expect_pkt(input int len, input logic [31:0] base);
    int nw, r;
    nw = (len + 3) / 4;
    r = len % 4;
    for (int i = 0; i < nw; i++)
      exp_q.push_back('{d: base + 32'(i), k: (i == nw - 1 && r != 0) ? 4'(4'hF >> (4 - r)) : 4'hF, l: i == nw - 1});
  endtask

  task automatic clr_stats();
    nbeats = 0; npops = 0; gap = 0; first_cyc = 0; last_cyc = 0; done_seen = 1'b0;
  endtask

  task automatic send(input int len);
    cmd_len = 16'(len);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget && !done_seen; n++) step();
    chk("done_within_budget", 64'(done_seen), 64'(1));
  endtask

  initial begin
    step();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_read_en", 64'(fifo_read_enable), 64'(0));
    chk("rst_tdata_tkeep_tlast", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'(0));
    rst = 1'b1;
    step();
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

    clr_stats();
    load(4, 32'hA000_0000);
    expect_pkt(16, 32'hA000_0000);
    send(16);
    wait_done(40);
    chk("t1_beats", 64'(nbeats), 64'(4));
    chk("t1_back_to_back", 64'(last_cyc - first_cyc), 64'(3));
    chk("t1_first_latency", 64'(first_cyc - acc_cyc), 64'(3));
    chk("t1_pops", 64'(npops), 64'(4));
    chk("t1_last_keep", 64'(last_keep), 64'(4'hF));
    chk("t1_idle_cmd_ready", 64'(cmd_ready), 64'(1));

    clr_stats();
    load(2, 32'hB000_0000);
    expect_pkt(6, 32'hB000_0000);
    send(6);
    wait_done(40);
    chk("t2_beats", 64'(nbeats), 64'(2));
    chk("t2_last_keep", 64'(last_keep), 64'(4'b0011));
    chk("t2_pops", 64'(npops), 64'(2));
    chk("t2_fifo_left", 64'(fifo_q.size()), 64'(0));

    clr_stats();
    load(8, 32'hC000_0000);
    expect_pkt(32, 32'hC000_0000);
    send(32);
    for (int n = 0; n < 100 && !done_seen; n++) begin
      m_axis_tready = ~m_axis_tready;
      step();
    end
    m_axis_tready = 1'b1;
    chk("t3_done", 64'(done_seen), 64'(1));
    chk("t3_beats", 64'(nbeats), 64'(8));
    chk("t3_pops", 64'(npops), 64'(8));

    clr_stats();
    load(1, 32'hD000_0000);
    expect_pkt(12, 32'hD000_0000);
    send(12);
    for (int n = 0; n < 20 && nbeats == 0; n++) step();
    chk("t4_first_beat", 64'(nbeats), 64'(1));
    repeat (5) step();
    load(2, 32'hD000_0001);
    wait_done(40);
    chk("t4_beats", 64'(nbeats), 64'(3));
    chk("t4_tvalid_gap", 64'(gap >= 5), 64'(1));
    chk("t4_pops", 64'(npops), 64'(3));

    clr_stats();
    send(0);
    step();
    chk("t5_done_pulse", 64'(done_seen), 64'(1));
    chk("t5_beats", 64'(nbeats), 64'(0));
    chk("t5_pops", 64'(npops), 64'(0));
    chk("t5_cmd_ready", 64'(cmd_ready), 64'(1));

    clr_stats();
    load(8, 32'hE000_0000);
    expect_pkt(32, 32'hE000_0000);
    send(32);
    repeat (3) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t6_clear_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("t6_clear_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("t6_clear_busy", 64'(busy), 64'(0));
    chk("t6_clear_fifo_left", 64'(fifo_q.size()), 64'(5));
    step();
    fifo_q.delete();
    fifo_empty = 1'b1;

    clr_stats();
    load(8, 32'hF000_0000);
    expect_pkt(32, 32'hF000_0000);
    send(32);
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("t6_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_read_en", 64'(fifo_read_enable), 64'(0));
    chk("t6_rst_cmd_ready", 64'(cmd_ready), 64'(0));
    exp_q.delete();
    outst = 0;
    done_next = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("t6_rst_cmd_ready_after", 64'(cmd_ready), 64'(1));
    chk("t6_rst_fifo_left", 64'(fifo_q.size()), 64'(5));
    fifo_q.delete();
    fifo_empty = 1'b1;

    clr_stats();
    load(3, 32'h1234_0000);
    expect_pkt(10, 32'h1234_0000);
    send(10);
    wait_done(40);
    chk("t7_beats", 64'(nbeats), 64'(3));
    chk("t7_last_keep", 64'(last_keep), 64'(4'b0011));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
